// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : shift_seq_ctrl
//  Brief    : Command sequencer (LOAD/SHL/SHR/BOUNCE) for a bidirectional
//             shift register, with a programmable step divider.
//             Optional SHIFT_SEQ_PAUSE_EN adds an i_pause port that stalls RUN.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 5,
   parameter int DIV_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [1:0]       i_cmd_op,
   input  logic [CNT_W-1:0] i_cmd_count,
   input  logic [WIDTH-1:0] i_cmd_data,
   input  logic [DIV_W-1:0] i_cfg_div,
   output logic             o_sr_load,
   output logic [WIDTH-1:0] o_sr_din,
   output logic             o_sr_shift_en,
   output logic             o_sr_dir,
   output logic             o_busy,
   output logic             o_done,
   output logic [CNT_W-1:0] o_step_cnt
`ifdef SHIFT_SEQ_PAUSE_EN
   ,
   input  logic             i_pause
`endif
);

   localparam logic [1:0] c_OP_LOAD   = 2'b00;
   localparam logic [1:0] c_OP_SHR    = 2'b10;
   localparam logic [1:0] c_OP_BOUNCE = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           r_state, w_state_nx;
   logic [DIV_W-1:0] r_div, w_div_nx;
   logic [DIV_W-1:0] r_div_cnt, w_div_cnt_nx;
   logic [CNT_W-1:0] r_step_cnt, w_step_cnt_nx;
   logic [CNT_W-1:0] r_count, w_count_nx;
   logic             r_bounce, w_bounce_nx;
   logic             r_phase2, w_phase2_nx;
   logic             r_dir, w_dir_nx;
   logic [WIDTH-1:0] r_din, w_din_nx;
   logic             w_stall;
   logic             w_accept;

`ifdef SHIFT_SEQ_PAUSE_EN
   assign w_stall = i_pause;
`else
   assign w_stall = 1'b0;
`endif

   assign w_accept = i_cmd_valid && (r_state == S_IDLE);

   always_comb begin
      w_state_nx    = r_state;
      w_div_nx      = r_div;
      w_div_cnt_nx  = r_div_cnt;
      w_step_cnt_nx = r_step_cnt;
      w_count_nx    = r_count;
      w_bounce_nx   = r_bounce;
      w_phase2_nx   = r_phase2;
      w_dir_nx      = r_dir;
      w_din_nx      = r_din;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (i_cmd_op == c_OP_LOAD) begin
                  w_din_nx   = i_cmd_data;
                  w_state_nx = S_LOAD;
               end else begin
                  w_count_nx    = i_cmd_count;
                  w_step_cnt_nx = i_cmd_count;
                  w_div_nx      = i_cfg_div;
                  w_div_cnt_nx  = i_cfg_div;
                  w_bounce_nx   = (i_cmd_op == c_OP_BOUNCE);
                  w_phase2_nx   = 1'b0;
                  w_dir_nx      = (i_cmd_op != c_OP_SHR);
                  w_state_nx    = (i_cmd_count == '0) ? S_DONE : S_RUN;
               end
            end
         end
         S_LOAD: w_state_nx = S_DONE;
         S_RUN: begin
            if (!w_stall) begin
               if (r_div_cnt == '0) begin
                  w_div_cnt_nx = r_div;
                  if (r_step_cnt == CNT_W'(1)) begin
                     // End of the left phase of a bounce turns around instead of finishing
                     if (r_bounce && !r_phase2) begin
                        w_phase2_nx   = 1'b1;
                        w_step_cnt_nx = r_count;
                        w_dir_nx      = 1'b0;
                     end else begin
                        w_step_cnt_nx = '0;
                        w_state_nx    = S_DONE;
                     end
                  end else begin
                     w_step_cnt_nx = r_step_cnt - CNT_W'(1);
                  end
               end else begin
                  w_div_cnt_nx = r_div_cnt - DIV_W'(1);
               end
            end
         end
         S_DONE: w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_div      <= '0;
         r_div_cnt  <= '0;
         r_step_cnt <= '0;
         r_count    <= '0;
         r_bounce   <= 1'b0;
         r_phase2   <= 1'b0;
         r_dir      <= 1'b0;
         r_din      <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_div      <= w_div_nx;
         r_div_cnt  <= w_div_cnt_nx;
         r_step_cnt <= w_step_cnt_nx;
         r_count    <= w_count_nx;
         r_bounce   <= w_bounce_nx;
         r_phase2   <= w_phase2_nx;
         r_dir      <= w_dir_nx;
         r_din      <= w_din_nx;
      end
   end

   assign o_cmd_ready   = (r_state == S_IDLE);
   assign o_busy        = (r_state != S_IDLE);
   assign o_done        = (r_state == S_DONE);
   assign o_sr_load     = (r_state == S_LOAD);
   assign o_sr_shift_en = (r_state == S_RUN) && (r_div_cnt == '0) && !w_stall;
   assign o_sr_dir      = r_dir;
   assign o_sr_din      = r_din;
   assign o_step_cnt    = r_step_cnt;

endmodule
`default_nettype wire
